// File: rtl/cla_subtractor_seq_if.sv
// Handshake and data bundle for the nibble-serial CLA subtractor.
// The slave side (the subtractor) takes operands and returns diff, borrow and zero.
interface cla_subtractor_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero
    );
endinterface

// File: rtl/cla_subtractor_seq.sv
// Sequential subtractor: computes a - b one 4-bit nibble per cycle, LSB first,
// as a + ~b + 1 using a 4-bit carry-lookahead cell and a registered carry.
// Results sit in registered outputs and hold until the consumer takes them.
module cla_subtractor_seq #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    cla_subtractor_seq_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [IDXW+1:0]  base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum;

    // One nibble of a + ~b + carry_in with all carries formed in parallel from G/P.
    always_comb begin
        base  = {idx_q, 2'b00};
        a_nib = a_q[base +: 4];
        b_nib = b_q[base +: 4];
        g     = a_nib & ~b_nib;
        p     = a_nib | ~b_nib;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum   = a_nib ^ ~b_nib ^ c[3:0];
    end

    // Next-state logic: accept in IDLE, step nibbles in CALC, hold the result in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                diff_d[base +: 4] = sum;
                carry_d           = c[4];
                idx_d             = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    borrow_d = ~c[4];
                    zero_d   = ~|diff_d;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;
endmodule
